dpram_port_scheduler: RTL and testbench

//  Shares one true dual-port RAM (ports A/B, 8-bit address, 16-bit data, synchronous

---
 rtl/dpram_pkg.sv | 19 +
 rtl/dpram_port_scheduler_rr_pick2.sv | 40 ++++
 rtl/dpram_port_scheduler.sv | 156 +++++++++++++++
 tb/tb_dpram_port_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dpram_pkg : shared defaults and helpers for the dual-port scheduler  |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package dpram_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dpram_port_scheduler_rr_pick2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick2 : finds the first two valid requesters in round-robin order |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module rr_pick2 #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [IDW-1:0]  first_o,
  output logic            first_found_o,
  output logic [IDW-1:0]  second_o,
  output logic            second_found_o
);

  always_comb begin : p_scan
    int j;
    j              = 0;
    first_o        = '0;
    first_found_o  = 1'b0;
    second_o       = '0;
    second_found_o = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (valid_i[j]) begin
        if (!first_found_o) begin
          first_o       = IDW'(j);
          first_found_o = 1'b1;
        end else if (!second_found_o) begin
          second_o       = IDW'(j);
          second_found_o = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dpram_port_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dpram_port_scheduler : round-robin two-port arbiter for a true DPRAM |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
module dpram_port_scheduler
  import dpram_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [NREQ*DW-1:0] rsp_rdata,
  output logic             ena,
  output logic             enb,
  output logic             wea,
  output logic             web,
  output logic [AW-1:0]    addra,
  output logic [AW-1:0]    addrb,
  output logic [DW-1:0]    dina,
  output logic [DW-1:0]    dinb,
  input  logic [DW-1:0]    douta,
  input  logic [DW-1:0]    doutb,
  output logic [15:0]      conflict_cnt
);

  localparam int IDW = id_width(NREQ);

  typedef struct packed {
    logic           en;
    logic           we;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  din;
    logic [IDW-1:0] id;
  } cmd_t;

  cmd_t           cmd_q [2];
  cmd_t           cmd_d [2];
  logic [RD_LAT-1:0] tv_q [2];
  logic [IDW-1:0]    tid_q [2][RD_LAT];
  logic [IDW-1:0]    rr_q, rr_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [IDW-1:0] p_idx, q_idx, last_idx;
  logic           p_found, q_found, hazard, grant_b;
  logic [AW-1:0]  p_addr, q_addr;
  logic           p_we, q_we;
  logic [DW-1:0]  dout_w [2];

  rr_pick2 #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .valid_i       (req_valid),
    .ptr_i         (rr_q),
    .first_o       (p_idx),
    .first_found_o (p_found),
    .second_o      (q_idx),
    .second_found_o(q_found)
  );

  // Port B only looks at the very next candidate, so same-address order is kept.
  always_comb begin
    p_addr   = req_addr[int'(p_idx)*AW +: AW];
    q_addr   = req_addr[int'(q_idx)*AW +: AW];
    p_we     = req_we[p_idx];
    q_we     = req_we[q_idx];
    hazard   = p_found && q_found && (p_addr == q_addr) && (p_we || q_we);
    grant_b  = p_found && q_found && !hazard;

    req_ready = '0;
    if (p_found) req_ready[p_idx] = 1'b1;
    if (grant_b) req_ready[q_idx] = 1'b1;

    cmd_d[PORT_A]    = cmd_q[PORT_A];
    cmd_d[PORT_A].en = p_found;
    cmd_d[PORT_A].we = p_found && p_we;
    if (p_found) begin
      cmd_d[PORT_A].addr = p_addr;
      cmd_d[PORT_A].din  = req_wdata[int'(p_idx)*DW +: DW];
      cmd_d[PORT_A].id   = p_idx;
    end
    cmd_d[PORT_B]    = cmd_q[PORT_B];
    cmd_d[PORT_B].en = grant_b;
    cmd_d[PORT_B].we = grant_b && q_we;
    if (grant_b) begin
      cmd_d[PORT_B].addr = q_addr;
      cmd_d[PORT_B].din  = req_wdata[int'(q_idx)*DW +: DW];
      cmd_d[PORT_B].id   = q_idx;
    end

    last_idx = grant_b ? q_idx : p_idx;
    rr_d     = rr_q;
    if (p_found) rr_d = (int'(last_idx) == NREQ-1) ? '0 : last_idx + 1'b1;

    cnt_d = cnt_q;
    if (hazard && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  // The command register is the first tag stage; the pipe adds RD_LAT more.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        cmd_q[p] <= '0;
        tv_q[p]  <= '0;
        for (int s = 0; s < RD_LAT; s++) tid_q[p][s] <= '0;
      end
      rr_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        cmd_q[p]    <= cmd_d[p];
        tv_q[p][0]  <= cmd_q[p].en && !cmd_q[p].we;
        tid_q[p][0] <= cmd_q[p].id;
        for (int s = 1; s < RD_LAT; s++) begin
          tv_q[p][s]  <= tv_q[p][s-1];
          tid_q[p][s] <= tid_q[p][s-1];
        end
      end
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout_w[PORT_A] = douta;
  assign dout_w[PORT_B] = doutb;

  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int p = 0; p < 2; p++) begin
      if (tv_q[p][RD_LAT-1]) begin
        rsp_valid[tid_q[p][RD_LAT-1]]                          = 1'b1;
        rsp_rdata[int'(tid_q[p][RD_LAT-1])*DW +: DW] = dout_w[p];
      end
    end
  end

  assign ena          = cmd_q[PORT_A].en;
  assign wea          = cmd_q[PORT_A].we;
  assign addra        = cmd_q[PORT_A].addr;
  assign dina         = cmd_q[PORT_A].din;
  assign enb          = cmd_q[PORT_B].en;
  assign web          = cmd_q[PORT_B].we;
  assign addrb        = cmd_q[PORT_B].addr;
  assign dinb         = cmd_q[PORT_B].din;
  assign conflict_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dpram_port_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dpram_port_scheduler : directed bench with response scoreboard    |
// | Revision                : 1.0                                        |
// +----------------------------------------------------------------------+
module tb_dpram_port_scheduler;

  localparam int NREQ   = 4;
  localparam int AW     = 8;
  localparam int DW     = 16;
  localparam int RD_LAT = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata, rsp_rdata;
  logic              ena, enb, wea, web;
  logic [AW-1:0]     addra, addrb;
  logic [DW-1:0]     dina, dinb, douta, doutb;
  logic [15:0]       conflict_cnt;

  logic [DW-1:0] mem [256];

  typedef struct {
    int          id;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dpram_port_scheduler #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .ena         (ena),
    .enb         (enb),
    .wea         (wea),
    .web         (web),
    .addra       (addra),
    .addrb       (addrb),
    .dina        (dina),
    .dinb        (dinb),
    .douta       (douta),
    .doutb       (doutb),
    .conflict_cnt(conflict_cnt)
  );

  // Synchronous-read true dual-port RAM, one cycle of read latency.
  always @(posedge clk) begin
    if (ena) begin
      if (wea) mem[addra] <= dina;
      else     douta      <= mem[addra];
    end
    if (enb) begin
      if (web) mem[addrb] <= dinb;
      else     doutb      <= mem[addrb];
    end
  end

  // Scoreboard monitor: every response must match a pushed expectation on its due cycle.
  always @(negedge clk) begin
    int hit;
    for (int i = 0; i < NREQ; i++) begin
      if (rsp_valid[i]) begin
        hit = -1;
        for (int e = 0; e < sb.size(); e++)
          if (hit < 0 && sb[e].id == i) hit = e;
        checks++;
        if (hit < 0) begin
          errors++;
          $display("FAIL rsp_unexpected id=%0d cyc=%0d got=%h expected none", i, cyc,
                   rsp_rdata[i*DW +: DW]);
        end else begin
          if (sb[hit].data !== rsp_rdata[i*DW +: DW] || sb[hit].due != cyc) begin
            errors++;
            $display("FAIL rsp_id%0d got=%h at cyc %0d expected=%h at cyc %0d", i,
                     rsp_rdata[i*DW +: DW], cyc, sb[hit].data, sb[hit].due);
          end
          sb.delete(hit);
        end
      end
    end
    for (int e = sb.size() - 1; e >= 0; e--) begin
      if (sb[e].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL rsp_missing id=%0d got=none expected=%h at cyc %0d",
                 sb[e].id, sb[e].data, sb[e].due);
        sb.delete(e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic drive(input int i, input logic w, input logic [7:0] a, input logic [15:0] d);
    req_valid[i]          = 1'b1;
    req_we[i]             = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Check grants mid-cycle, then advance past the acceptance edge.
  task automatic tick(input logic [3:0] exp_ready, input string name);
    @(negedge clk);
    chk(name, {28'd0, req_ready}, {28'd0, exp_ready});
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input int id, input logic [15:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    e.due  = cyc + RD_LAT;
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ram_side", {28'd0, ena, enb, wea, web}, 32'd0);
    chk("reset_rsp_valid", {28'd0, rsp_valid}, 32'd0);
    chk("reset_cnt", {16'd0, conflict_cnt}, 32'd0);

    // Read accepted, then reset before it can respond.
    drive(0, 1'b0, 8'h10, 16'h0);
    tick(4'b0001, "t1_ready");
    clear();
    rst = 1'b1;
    #1;
    chk("t1_ena_after_rst", {31'd0, ena}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t1_rsp_during_rst", {28'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Two writes to different addresses share both ports.
    drive(0, 1'b1, 8'h00, 16'd9);
    drive(1, 1'b1, 8'h01, 16'd10);
    tick(4'b0011, "t2_ready");
    chk("t2_porta", {ena, wea, addra, dina}, {1'b1, 1'b1, 8'h00, 16'd9});
    chk("t2_portb", {enb, web, addrb, dinb}, {1'b1, 1'b1, 8'h01, 16'd10});

    // Write/read hazard on 8'h02: the read is deferred one cycle.
    clear();
    drive(0, 1'b1, 8'h02, 16'd7);
    drive(1, 1'b0, 8'h02, 16'd0);
    tick(4'b0001, "t3_ready_hazard");
    chk("t3_cnt", {16'd0, conflict_cnt}, 32'd1);
    chk("t3_enb_idle", {31'd0, enb}, 32'd0);
    clear();
    drive(1, 1'b0, 8'h02, 16'd0);
    tick(4'b0010, "t3_ready_deferred");
    expect_rsp(1, 16'd7);

    // Preload 8'h04..8'h07, then four reads held two cycles.
    clear();
    drive(0, 1'b1, 8'h04, 16'h1004);
    drive(1, 1'b1, 8'h05, 16'h1005);
    tick(4'b0011, "t4_wr01");
    clear();
    drive(2, 1'b1, 8'h06, 16'h1006);
    drive(3, 1'b1, 8'h07, 16'h1007);
    tick(4'b1100, "t4_wr23");
    clear();
    for (int i = 0; i < NREQ; i++) drive(i, 1'b0, 8'(8'h04 + i), 16'h0);
    tick(4'b0011, "t4_rd_grant01");
    expect_rsp(0, 16'h1004);
    expect_rsp(1, 16'h1005);
    tick(4'b1100, "t4_rd_grant23");
    expect_rsp(2, 16'h1006);
    expect_rsp(3, 16'h1007);

    // Lone requester always lands on port A.
    clear();
    drive(2, 1'b0, 8'h06, 16'h0);
    for (int n = 0; n < 3; n++) begin
      tick(4'b0100, "t5_ready_lone");
      expect_rsp(2, 16'h1006);
      chk("t5_ports", {ena, enb, addra}, {1'b1, 1'b0, 8'h06});
    end
    // Pointer now sits at 3: requester 3 wins port A over requester 0.
    clear();
    drive(0, 1'b0, 8'h00, 16'h0);
    drive(3, 1'b0, 8'h01, 16'h0);
    tick(4'b1001, "t5_ready_rr3");
    chk("t5_rr_addr", {enb, addra, addrb}, {1'b1, 8'h01, 8'h00});
    expect_rsp(3, 16'd10);
    expect_rsp(0, 16'd9);

    // Persistent write/write hazard drives the counter into saturation.
    clear();
    drive(0, 1'b1, 8'h08, 16'd1);
    drive(1, 1'b1, 8'h08, 16'd2);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("t6_cnt_101", {16'd0, conflict_cnt}, 32'd101);
    repeat (69900) @(posedge clk);
    @(negedge clk);
    chk("t6_cnt_sat", {16'd0, conflict_cnt}, 32'h0000FFFF);

    clear();
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
